// File: rtl/digi_pkg.sv
// Shared definitions for the digitizer readout control path.
package digi_pkg;

  localparam int ADC_WIDTH = 12;

  typedef enum logic [2:0] {
    IDLE,
    OFFSET_WAIT,
    SELECT,
    READ,
    DONE
  } state_t;

  // Ceiling log2, never below 1 so single-entry selects still get a bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hi_prio_enc.sv
// Combinational highest-set-bit encoder with an "all clear" flag.
module hi_prio_enc
  import digi_pkg::*;
#(
  parameter int CHAN = 8,
  localparam int SELW = clog2(CHAN)
) (
  input  logic [CHAN-1:0] req,
  output logic [SELW-1:0] idx,
  output logic            none
);

  // Later (higher) bits overwrite earlier ones, so the top set bit wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < CHAN; i++) begin
      if (req[i]) idx = SELW'(i);
    end
  end

  assign none = ~|req;

endmodule

// File: rtl/readout_sched.sv
// Per-event readout sequencer: EOS -> offset wait -> serve enabled channels high to low.
// Optional per-channel word watchdog is built when READOUT_WDOG_EN is defined.
module readout_sched
  import digi_pkg::*;
#(
  parameter int CHAN = 8,
  parameter int SIZE = 8,
  parameter int CNTW = 12,
  localparam int SELW = clog2(CHAN)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            EOS,
  input  logic [CHAN-1:0] CHAN_EN,
  input  logic [SIZE-1:0] OFFSET,
  input  logic [CNTW-1:0] HOW_MANY,
  input  logic            RD_EN,
  input  logic [CHAN-1:0] CH_DONE,
  output logic [CHAN-1:0] RD_REQUEST,
  output logic [SELW-1:0] SEL,
  output logic            BUSY,
  output logic            SPI_COMPLETE,
  output logic            OVERRUN,
  output logic [CHAN-1:0] ERR
);

  state_t          state;
  logic [CHAN-1:0] pending;
  logic [SIZE-1:0] ocnt;
  logic [CNTW-1:0] wcnt;
  logic [CHAN-1:0] err_q;
  logic [SELW-1:0] top_idx;
  logic            none;
  logic            accept;
  logic            last_word;
  logic            wdog_hit;

  hi_prio_enc #(.CHAN(CHAN)) u_enc (
    .req (pending),
    .idx (top_idx),
    .none(none)
  );

  assign accept     = (state == READ) && RD_EN;
  assign last_word  = accept && CH_DONE[SEL];
  assign RD_REQUEST = accept ? (CHAN'(1) << SEL) : '0;

`ifdef READOUT_WDOG_EN
  // wcnt holds words accepted before this one; this word would be HOW_MANY+1.
  assign wdog_hit = accept && !CH_DONE[SEL] && (HOW_MANY != '0) && (wcnt == HOW_MANY);
  assign ERR      = err_q;
`else
  logic unused_wdog;
  assign wdog_hit    = 1'b0;
  assign ERR         = '0;
  assign unused_wdog = ^{HOW_MANY, wcnt, err_q};
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state        <= IDLE;
      pending      <= '0;
      ocnt         <= '0;
      wcnt         <= '0;
      SEL          <= '0;
      BUSY         <= 1'b0;
      SPI_COMPLETE <= 1'b0;
      OVERRUN      <= 1'b0;
      err_q        <= '0;
    end else begin
      SPI_COMPLETE <= 1'b0;
      if (EOS && state != IDLE) OVERRUN <= 1'b1;
      case (state)
        IDLE: begin
          if (EOS) begin
            pending <= CHAN_EN;
            ocnt    <= OFFSET;
            err_q   <= '0;
            OVERRUN <= 1'b0;
            BUSY    <= 1'b1;
            state   <= (OFFSET != '0) ? OFFSET_WAIT : SELECT;
          end
        end
        OFFSET_WAIT: begin
          ocnt <= ocnt - 1'b1;
          if (ocnt == SIZE'(1)) state <= SELECT;
        end
        SELECT: begin
          if (none) begin
            SPI_COMPLETE <= 1'b1;
            state        <= DONE;
          end else begin
            SEL   <= top_idx;
            wcnt  <= '0;
            state <= READ;
          end
        end
        READ: begin
          if (RD_EN && wcnt != '1) wcnt <= wcnt + 1'b1;
          if (last_word || wdog_hit) begin
            pending[SEL] <= 1'b0;
            state        <= SELECT;
          end
          if (wdog_hit) err_q[SEL] <= 1'b1;
        end
        DONE: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_readout_sched.sv
// Randomized bench for readout_sched with a schedule-level reference model.
module tb_readout_sched;

  localparam int MAXC = 1024;

  logic       CLK = 1'b0;
  logic       RST_N, EOS, RD_EN;
  logic [7:0] CHAN_EN, CH_DONE, OFFSET, RD_REQUEST, ERR;
  logic [11:0] HOW_MANY;
  logic [2:0] SEL;
  logic       BUSY, SPI_COMPLETE, OVERRUN;

  readout_sched #(.CHAN(8), .SIZE(8), .CNTW(12)) dut (
    .CLK(CLK), .RST_N(RST_N), .EOS(EOS), .CHAN_EN(CHAN_EN), .OFFSET(OFFSET),
    .HOW_MANY(HOW_MANY), .RD_EN(RD_EN), .CH_DONE(CH_DONE),
    .RD_REQUEST(RD_REQUEST), .SEL(SEL), .BUSY(BUSY),
    .SPI_COMPLETE(SPI_COMPLETE), .OVERRUN(OVERRUN), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  logic [7:0] drv_done [MAXC];
  logic       drv_rden [MAXC];
  logic [7:0] exp_req  [MAXC];
  logic       exp_busy [MAXC];
  logic       exp_cmp  [MAXC];
  logic [7:0] obs_req  [MAXC];
  logic       obs_busy [MAXC];
  logic       obs_cmp  [MAXC];
  logic       obs_ovr  [MAXC];
  logic [7:0] obs_err  [MAXC];
  logic [7:0] exp_err;
  int         nwords [8];
  logic [7:0] nodone;
  int         sched_len;
  int         passes = 0;
  int         total  = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Model: the event is a list of channel bursts, highest enabled channel first.
  // Cycle 0 carries EOS, cycles 1..off wait, then one SELECT cycle before each burst
  // and after the last one, then the DONE cycle carrying SPI_COMPLETE.
  task automatic build(input logic [7:0] en, input int off, input int mode, input int hm);
    int  c, w;
    bit  fin, r;
    for (int i = 0; i < MAXC; i++) begin
      drv_done[i] = 8'h00; drv_rden[i] = 1'b0; exp_req[i] = 8'h00;
      exp_busy[i] = 1'b0;  exp_cmp[i]  = 1'b0;
    end
    exp_err = 8'h00;
    c = off + 1;
    for (int ch = 7; ch >= 0; ch--) begin
      if (en[ch]) begin
        w = 0; fin = 0; c++;
        while (!fin && c < MAXC - 4) begin
          if (mode == 0)      r = 1'b1;
          else if (mode == 1) r = (c % 2) == 0;
          else                r = ($urandom_range(0, 2) != 0);
          drv_rden[c] = r;
          drv_done[c] = 8'($urandom_range(0, 255));
          if (nodone[ch]) drv_done[c][ch] = 1'b0;
          if (r) begin
            w++;
            exp_req[c] = 8'h01 << ch;
            if (nodone[ch]) begin
              if (hm != 0 && w == hm + 1) begin fin = 1; exp_err[ch] = 1'b1; end
            end else begin
              drv_done[c][ch] = (w == nwords[ch]);
              fin = (w == nwords[ch]);
            end
          end
          c++;
        end
      end
    end
    exp_cmp[c + 1] = 1'b1;
    for (int i = 1; i <= c + 1; i++) exp_busy[i] = 1'b1;
    sched_len = c + 3;
  endtask

  // Applies the built stimulus; CHAN_EN/OFFSET are scrambled after cycle 0.
  task automatic drive(input logic [7:0] en, input logic [7:0] off, input int eos_at, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      EOS     = (c == 0) || (c == eos_at);
      CHAN_EN = (c == 0) ? en  : 8'($urandom_range(0, 255));
      OFFSET  = (c == 0) ? off : 8'($urandom_range(0, 255));
      RD_EN   = drv_rden[c];
      CH_DONE = drv_done[c];
      @(negedge CLK);
      obs_req[c] = RD_REQUEST; obs_busy[c] = BUSY; obs_cmp[c] = SPI_COMPLETE;
      obs_ovr[c] = OVERRUN;    obs_err[c]  = ERR;
      tick();
    end
    EOS = 1'b0; RD_EN = 1'b0; CH_DONE = 8'h00;
  endtask

  task automatic set_words(input int lo, input int hi);
    for (int i = 0; i < 8; i++) nwords[i] = $urandom_range(lo, hi);
  endtask

  task automatic test_reset();
    RST_N = 1'b0; RD_EN = 1'b1; EOS = 1'b1; CHAN_EN = 8'hFF; OFFSET = 8'h00;
    tick();
    @(negedge CLK);
    total++;
    if ({RD_REQUEST, SEL, BUSY, SPI_COMPLETE, OVERRUN, ERR} !== 22'h0) begin
      $display("FAIL reset_outputs: got req=%h sel=%0d busy=%b cmp=%b ovr=%b err=%h want all 0",
               RD_REQUEST, SEL, BUSY, SPI_COMPLETE, OVERRUN, ERR);
    end else passes++;
    RST_N = 1'b1; EOS = 1'b0; RD_EN = 1'b0;
    tick();
  endtask

  task automatic test_all_channels();
    int pulses;
    for (int i = 0; i < 8; i++) nwords[i] = 4;
    nodone = 8'h00;
    build(8'hFF, 0, 0, 0);
    drive(8'hFF, 8'd0, -1, sched_len);
    pulses = 0;
    for (int c = 0; c < sched_len; c++) begin
      pulses += int'(obs_cmp[c]);
      total++;
      if ({obs_req[c], obs_busy[c], obs_cmp[c]} !== {exp_req[c], exp_busy[c], exp_cmp[c]})
        $display("FAIL all_channels cycle %0d: got req=%h busy=%b cmp=%b want req=%h busy=%b cmp=%b",
                 c, obs_req[c], obs_busy[c], obs_cmp[c], exp_req[c], exp_busy[c], exp_cmp[c]);
      else passes++;
    end
    total++;
    if (pulses !== 1) $display("FAIL all_channels_pulses: got %0d want 1", pulses);
    else passes++;
  endtask

  task automatic test_offset();
    set_words(1, 6);
    nodone = 8'h00;
    build(8'b0010_0100, 5, 0, 0);
    drive(8'b0010_0100, 8'd5, -1, sched_len);
    total++;
    if (obs_req[7] !== 8'h20 || obs_req[6] !== 8'h00)
      $display("FAIL offset_first_strobe: got c6=%h c7=%h want c6=00 c7=20", obs_req[6], obs_req[7]);
    else passes++;
    for (int c = 0; c < sched_len; c++) begin
      total++;
      if ({obs_req[c], obs_busy[c], obs_cmp[c]} !== {exp_req[c], exp_busy[c], exp_cmp[c]})
        $display("FAIL offset cycle %0d: got req=%h busy=%b cmp=%b want req=%h busy=%b cmp=%b",
                 c, obs_req[c], obs_busy[c], obs_cmp[c], exp_req[c], exp_busy[c], exp_cmp[c]);
      else passes++;
    end
  endtask

  task automatic test_rden_toggle();
    logic [7:0] en;
    int off;
    for (int it = 0; it < 4; it++) begin
      en  = 8'($urandom_range(1, 255));
      off = $urandom_range(0, 7);
      set_words(1, 5);
      nodone = 8'h00;
      build(en, off, 1, 0);
      drive(en, 8'(off), -1, sched_len);
      for (int c = 0; c < sched_len; c++) begin
        total++;
        if ({obs_req[c], obs_busy[c], obs_cmp[c]} !== {exp_req[c], exp_busy[c], exp_cmp[c]})
          $display("FAIL rden_toggle cycle %0d: got req=%h busy=%b cmp=%b want req=%h busy=%b cmp=%b",
                   c, obs_req[c], obs_busy[c], obs_cmp[c], exp_req[c], exp_busy[c], exp_cmp[c]);
        else passes++;
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] en;
    int off;
    for (int it = 0; it < 10; it++) begin
      en  = (it == 3) ? 8'h00 : 8'($urandom_range(0, 255));
      off = $urandom_range(0, 20);
      set_words(1, 7);
      nodone = 8'h00;
      build(en, off, 2, 0);
      drive(en, 8'(off), -1, sched_len);
      for (int c = 0; c < sched_len; c++) begin
        total++;
        if ({obs_req[c], obs_busy[c], obs_cmp[c]} !== {exp_req[c], exp_busy[c], exp_cmp[c]})
          $display("FAIL random cycle %0d: got req=%h busy=%b cmp=%b want req=%h busy=%b cmp=%b",
                   c, obs_req[c], obs_busy[c], obs_cmp[c], exp_req[c], exp_busy[c], exp_cmp[c]);
        else passes++;
      end
    end
  endtask

  task automatic test_all_disabled();
    nodone = 8'h00;
    build(8'h00, 0, 0, 0);
    drive(8'h00, 8'd0, -1, sched_len);
    total++;
    if (obs_cmp[2] !== 1'b1 || obs_cmp[1] !== 1'b0 || obs_busy[3] !== 1'b0)
      $display("FAIL all_disabled_timing: got cmp1=%b cmp2=%b busy3=%b want 0 1 0",
               obs_cmp[1], obs_cmp[2], obs_busy[3]);
    else passes++;
    for (int c = 0; c < sched_len; c++) begin
      total++;
      if (obs_req[c] !== 8'h00) $display("FAIL all_disabled_req cycle %0d: got %h want 00", c, obs_req[c]);
      else passes++;
    end
  endtask

  task automatic test_overrun_reset();
    for (int i = 0; i < 8; i++) nwords[i] = 5;
    nodone = 8'h00;
    build(8'hFF, 2, 0, 0);
    drive(8'hFF, 8'd2, 6, 12);
    for (int c = 1; c < 12; c++) begin
      total++;
      if (obs_ovr[c] !== (c > 6) || obs_req[c] !== exp_req[c])
        $display("FAIL overrun cycle %0d: got ovr=%b req=%h want ovr=%b req=%h",
                 c, obs_ovr[c], obs_req[c], c > 6, exp_req[c]);
      else passes++;
    end
    RST_N = 1'b0; RD_EN = 1'b1; CH_DONE = 8'hFF;
    tick();
    @(negedge CLK);
    total++;
    if ({RD_REQUEST, SEL, BUSY, SPI_COMPLETE, OVERRUN, ERR} !== 22'h0)
      $display("FAIL midread_reset: got req=%h sel=%0d busy=%b cmp=%b ovr=%b err=%h want all 0",
               RD_REQUEST, SEL, BUSY, SPI_COMPLETE, OVERRUN, ERR);
    else passes++;
    RST_N = 1'b1; RD_EN = 1'b0; CH_DONE = 8'h00;
    tick();
    set_words(1, 4);
    build(8'b1000_0011, 1, 2, 0);
    drive(8'b1000_0011, 8'd1, -1, sched_len);
    for (int c = 0; c < sched_len; c++) begin
      total++;
      if ({obs_req[c], obs_busy[c], obs_cmp[c], obs_ovr[c]} !== {exp_req[c], exp_busy[c], exp_cmp[c], 1'b0})
        $display("FAIL after_reset cycle %0d: got req=%h busy=%b cmp=%b ovr=%b want req=%h busy=%b cmp=%b ovr=0",
                 c, obs_req[c], obs_busy[c], obs_cmp[c], obs_ovr[c], exp_req[c], exp_busy[c], exp_cmp[c]);
      else passes++;
    end
  endtask

`ifdef READOUT_WDOG_EN
  task automatic test_watchdog();
    HOW_MANY = 12'd3;
    nwords[7] = 2; nwords[6] = 1; nwords[0] = 3;
    nodone = 8'b0100_0000;
    build(8'b1100_0001, 0, 2, 3);
    drive(8'b1100_0001, 8'd0, -1, sched_len);
    for (int c = 0; c < sched_len; c++) begin
      total++;
      if ({obs_req[c], obs_busy[c], obs_cmp[c]} !== {exp_req[c], exp_busy[c], exp_cmp[c]})
        $display("FAIL watchdog cycle %0d: got req=%h busy=%b cmp=%b want req=%h busy=%b cmp=%b",
                 c, obs_req[c], obs_busy[c], obs_cmp[c], exp_req[c], exp_busy[c], exp_cmp[c]);
      else passes++;
    end
    total++;
    if (ERR !== exp_err || exp_err !== obs_err[sched_len - 1])
      $display("FAIL watchdog_err: got %h want %h", ERR, exp_err);
    else passes++;
    HOW_MANY = 12'd0;
    nodone = 8'h00;
    set_words(1, 3);
    build(8'h01, 0, 0, 0);
    drive(8'h01, 8'd0, -1, sched_len);
    total++;
    if (obs_err[1] !== 8'h00) $display("FAIL watchdog_err_clear: got %h want 00", obs_err[1]);
    else passes++;
  endtask
`endif

  initial begin
    RST_N = 1'b0; EOS = 1'b0; RD_EN = 1'b0; CH_DONE = 8'h00;
    CHAN_EN = 8'h00; OFFSET = 8'h00; HOW_MANY = 12'd0; nodone = 8'h00;
    for (int i = 0; i < 8; i++) nwords[i] = 1;
    tick(); tick();
    RST_N = 1'b1;
    tick();
    test_reset();
    test_all_channels();
    test_offset();
    test_rden_toggle();
    test_all_disabled();
    test_overrun_reset();
    test_random();
`ifdef READOUT_WDOG_EN
    test_watchdog();
`endif
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
